alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_if.sv | 42 ++++
 rtl/alu_core.sv | 147 ++++++++++++++
 tb/tb_alu_core.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if -- operand/result bundle for alu_core.
//
// Parameter:
//   DWIDTH  operand/result width in bits (2..64)
//
// Signals:
//   sel_i      [1:0]        operation select: 0=ADD 1=SUB 2=AND 3=OR
//   op1_i      [DWIDTH-1:0] operand A
//   op2_i      [DWIDTH-1:0] operand B
//   res_o      [DWIDTH-1:0] operation result
//   zero_o                  result is all zeros
//   neg_o                   result MSB
//   carry_o                 adder carry-out (ADD/SUB only)
//   ovf_o                   signed overflow (ADD/SUB only)
//   flags_q_o  [3:0]        registered {neg, zero, carry, ovf}
//
// Modports: master drives operands and select; slave is the ALU.
// -----------------------------------------------------------------------------
interface alu_if #(
  parameter int DWIDTH = 8
);
  logic [1:0]        sel_i;
  logic [DWIDTH-1:0] op1_i;
  logic [DWIDTH-1:0] op2_i;
  logic [DWIDTH-1:0] res_o;
  logic              zero_o;
  logic              neg_o;
  logic              carry_o;
  logic              ovf_o;
  logic [3:0]        flags_q_o;

  modport master (
    output sel_i, op1_i, op2_i,
    input  res_o, zero_o, neg_o, carry_o, ovf_o, flags_q_o
  );

  modport slave (
    input  sel_i, op1_i, op2_i,
    output res_o, zero_o, neg_o, carry_o, ovf_o, flags_q_o
  );
endinterface

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core -- 4-operation ALU (ADD, SUB, AND, OR) with status flags.
//
// Parameter:
//   DWIDTH  operand/result width in bits (2..64)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_if.slave: sel_i/op1_i/op2_i in; res_o, zero_o, neg_o,
//          carry_o, ovf_o, flags_q_o out
//
// Build option:
//   ALU_OUT_REG_EN  when defined, res/zero/neg/carry/ovf are registered
//                   (one cycle latency, cleared by reset) and flags_q_o
//                   follows those registered values one cycle later.
//                   When undefined, those outputs are purely combinational
//                   and unaffected by reset.
// -----------------------------------------------------------------------------
module alu_core #(
  parameter int DWIDTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam int MSB = DWIDTH - 1;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

  logic [DWIDTH-1:0] a;
  logic [DWIDTH-1:0] b;
  logic [DWIDTH-1:0] b_eff;
  logic              is_sub;
  logic [DWIDTH:0]   sum;

  logic [DWIDTH-1:0] res_c;
  logic              carry_c;
  logic              ovf_c;
  logic              zero_c;
  logic              neg_c;

  // Values presented on the output ports (combinational or registered).
  logic [DWIDTH-1:0] out_res;
  logic              out_zero;
  logic              out_neg;
  logic              out_carry;
  logic              out_ovf;

  assign a      = bus.op1_i;
  assign b      = bus.op2_i;
  assign is_sub = (bus.sel_i == OP_SUB);

  // One shared adder: SUB is A + ~B + 1, so its carry-out means "no borrow".
  assign b_eff = is_sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{DWIDTH{1'b0}}, is_sub};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    // An X select matches no item and falls to the default (all zeros).
    case (alu_op_e'(bus.sel_i))
      OP_ADD: begin
        res_c   = sum[MSB:0];
        carry_c = sum[DWIDTH];
        ovf_c   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res_c   = sum[MSB:0];
        carry_c = sum[DWIDTH];
        ovf_c   = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      default: ;
    endcase
  end

  assign zero_c = (res_c == '0);
  assign neg_c  = res_c[MSB];

`ifdef ALU_OUT_REG_EN
  logic [DWIDTH-1:0] res_q;
  logic              zero_q;
  logic              neg_q;
  logic              carry_q;
  logic              ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      res_q   <= res_c;
      zero_q  <= zero_c;
      neg_q   <= neg_c;
      carry_q <= carry_c;
      ovf_q   <= ovf_c;
    end
  end

  assign out_res   = res_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;
`else
  assign out_res   = res_c;
  assign out_zero  = zero_c;
  assign out_neg   = neg_c;
  assign out_carry = carry_c;
  assign out_ovf   = ovf_c;
`endif

  // Status snapshot of whatever the output ports currently show.
  logic [3:0] flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      // NOTE: registered state uses non-blocking assignment so every flop
      // samples its inputs from before the edge.
      flags_q <= {out_neg, out_zero, out_carry, out_ovf};
    end
  end

  assign bus.res_o     = out_res;
  assign bus.zero_o    = out_zero;
  assign bus.neg_o     = out_neg;
  assign bus.carry_o   = out_carry;
  assign bus.ovf_o     = out_ovf;
  assign bus.flags_q_o = flags_q;

endmodule

// File: tb/tb_alu_core.sv
// -----------------------------------------------------------------------------
// tb_alu_core -- self-checking bench for alu_core (DWIDTH=8, default build).
// Stimulus issues one operation per cycle and queues the reference result;
// a monitor on the falling edge pops and compares the combinational outputs
// and the flags register captured from the previous operation.
// -----------------------------------------------------------------------------
module tb_alu_core;

  localparam int DW   = 8;
  localparam int MODV = 1 << DW;
  localparam int HALF = MODV / 2;

  logic clk = 1'b0;
  logic rst_n;
  logic mon_en;

  always #5 clk = ~clk;

  alu_if #(.DWIDTH(DW)) bus ();

  alu_core #(.DWIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int        id;
    int        res;
    logic      zero;
    logic      neg;
    logic      carry;
    logic      ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic exp_t model(input int id, input int sel, input int a,
                                 input int b);
    exp_t e;
    int   sa, sb, s;
    sa      = (a >= HALF) ? a - MODV : a;
    sb      = (b >= HALF) ? b - MODV : b;
    e.id    = id;
    e.carry = 1'b0;
    e.ovf   = 1'b0;
    e.res   = 0;
    case (sel)
      0: begin
        e.res   = (a + b) % MODV;
        e.carry = (a + b) >= MODV;
        s       = sa + sb;
        e.ovf   = (s >= HALF) || (s < -HALF);
      end
      1: begin
        e.res   = (a - b + MODV) % MODV;
        e.carry = (a >= b);
        s       = sa - sb;
        e.ovf   = (s >= HALF) || (s < -HALF);
      end
      2: e.res = a & b;
      default: e.res = a | b;
    endcase
    e.zero = (e.res == 0);
    e.neg  = (e.res >= HALF);
    return e;
  endfunction

  int op_id = 0;

  task automatic issue(input int sel, input int a, input int b);
    @(posedge clk);
    #1;
    bus.sel_i = 2'(sel);
    bus.op1_i = DW'(a);
    bus.op2_i = DW'(b);
    sb_q.push_back(model(op_id, sel, a, b));
    op_id++;
  endtask

  // Monitor: compares the displayed operation and the flags captured from
  // the previous one.
  exp_t last;
  logic last_valid = 1'b0;

  always @(negedge clk) begin
    if (!mon_en) begin
      last_valid = 1'b0;
    end else if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (last_valid)
        check($sformatf("flags_q op%0d", last.id), 64'(bus.flags_q_o),
              64'({last.neg, last.zero, last.carry, last.ovf}));
      check($sformatf("res op%0d", e.id),   64'(bus.res_o),   64'(e.res));
      check($sformatf("zero op%0d", e.id),  64'(bus.zero_o),  64'(e.zero));
      check($sformatf("neg op%0d", e.id),   64'(bus.neg_o),   64'(e.neg));
      check($sformatf("carry op%0d", e.id), 64'(bus.carry_o), 64'(e.carry));
      check($sformatf("ovf op%0d", e.id),   64'(bus.ovf_o),   64'(e.ovf));
      last       = e;
      last_valid = 1'b1;
    end
  end

  // Directed vectors: {sel, a, b}
  int dir_sel[8] = '{0,    1,    1,    0,    1,    2,    3,    2};
  int dir_a[8]   = '{1,    0,    10,   127,  128,  255,  128,  240};
  int dir_b[8]   = '{2,    1,    3,    1,    1,    0,    1,    15};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    mon_en    = 1'b0;
    rst_n     = 1'b1;
    bus.sel_i = 2'd0;
    bus.op1_i = '0;
    bus.op2_i = '0;
    #3 rst_n = 1'b0;
    #1;
    check("flags_q in reset", 64'(bus.flags_q_o), 64'h0);
    // Combinational path is independent of reset.
    bus.op1_i = 8'd1;
    bus.op2_i = 8'd2;
    #1;
    check("res during reset", 64'(bus.res_o), 64'd3);
    @(posedge clk);
    #1;
    check("flags_q held in reset", 64'(bus.flags_q_o), 64'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) issue(dir_sel[i], dir_a[i], dir_b[i]);
    for (int i = 0; i < 50; i++)
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, MODV - 1)),
            int'($urandom_range(0, MODV - 1)));

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    mon_en = 1'b0;

    // Flags capture then asynchronous reset between edges.
    @(posedge clk);
    #1;
    bus.sel_i = 2'd0;
    bus.op1_i = 8'h7F;
    bus.op2_i = 8'h01;
    e = model(-1, 0, 'h7F, 1);
    @(posedge clk);
    #1;
    check("flags_q ADD 7F+1", 64'(bus.flags_q_o), 64'b1001);
    check("flags_q vs model", 64'(bus.flags_q_o),
          64'({e.neg, e.zero, e.carry, e.ovf}));
    #2 rst_n = 1'b0;
    #1;
    check("flags_q async clear", 64'(bus.flags_q_o), 64'h0);
    check("res unaffected by reset", 64'(bus.res_o), 64'h80);
    @(posedge clk);
    #1;
    check("flags_q stays clear", 64'(bus.flags_q_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("flags_q before first edge", 64'(bus.flags_q_o), 64'h0);
    @(posedge clk);
    #1;
    check("flags_q first capture", 64'(bus.flags_q_o), 64'b1001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
